// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the arbiter, its requesting masters and the memory port.
// The arbiter takes the slave modport; the masters and memory model take master.
interface mem_bus_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 26
);
    localparam int GRANT_WIDTH = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic [NUM_MASTERS-1:0]            M_REQ;
    logic [NUM_MASTERS-1:0]            M_WE;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] M_ADDR;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] M_WDATA;
    logic [NUM_MASTERS-1:0]            M_ACK;
    logic [DATA_WIDTH-1:0]             M_RDATA;
    logic [ADDR_WIDTH-1:0]             MEM_ADDR;
    logic [DATA_WIDTH-1:0]             MEM_DATA_OUT;
    logic [DATA_WIDTH-1:0]             MEM_DATA_IN;
    logic                              MEM_READ;
    logic                              MEM_WRITE;
    logic                              BUSY;
    logic [GRANT_WIDTH-1:0]            GRANT_ID;

    modport slave (
        input  M_REQ, M_WE, M_ADDR, M_WDATA, MEM_DATA_IN,
        output M_ACK, M_RDATA, MEM_ADDR, MEM_DATA_OUT, MEM_READ, MEM_WRITE, BUSY, GRANT_ID
    );

    modport master (
        output M_REQ, M_WE, M_ADDR, M_WDATA, MEM_DATA_IN,
        input  M_ACK, M_RDATA, MEM_ADDR, MEM_DATA_OUT, MEM_READ, MEM_WRITE, BUSY, GRANT_ID
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_MASTERS requesters,
// holding each access for ACCESS_CYCLES cycles and acknowledging with a one-cycle pulse.
module mem_bus_arbiter #(
    parameter int NUM_MASTERS   = 2,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 26,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              RST,
    mem_bus_arbiter_if.slave  bus
);
    localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [1:0]            state;
    logic [GW-1:0]         rr_ptr;
    logic [GW-1:0]         grant;
    logic [CW-1:0]         cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  we_q;

    logic                   found;
    logic [GW-1:0]          winner;
    logic [ADDR_WIDTH-1:0]  addr_sel;
    logic [DATA_WIDTH-1:0]  wdata_sel;
    logic                   we_sel;
    logic [NUM_MASTERS-1:0] req_rot;
    logic [NUM_MASTERS-1:0] we_rot;
    int unsigned            idx;

    // Scan from the round-robin pointer upward, wrapping at NUM_MASTERS.
    always_comb begin
        found     = 1'b0;
        winner    = '0;
        addr_sel  = '0;
        wdata_sel = '0;
        we_sel    = 1'b0;
        req_rot   = '0;
        we_rot    = '0;
        idx       = 0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            idx = 32'(rr_ptr) + i;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            req_rot = bus.M_REQ >> idx;
            if (!found && req_rot[0]) begin
                found     = 1'b1;
                winner    = GW'(idx);
                we_rot    = bus.M_WE >> idx;
                we_sel    = we_rot[0];
                addr_sel  = ADDR_WIDTH'(bus.M_ADDR >> (idx * ADDR_WIDTH));
                wdata_sel = DATA_WIDTH'(bus.M_WDATA >> (idx * DATA_WIDTH));
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= ST_IDLE;
            rr_ptr  <= '0;
            grant   <= '0;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        addr_q  <= addr_sel;
                        wdata_q <= wdata_sel;
                        we_q    <= we_sel;
                        grant   <= winner;
                        cnt     <= CW'(ACCESS_CYCLES - 1);
                        state   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (!we_q) rdata_q <= bus.MEM_DATA_IN;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Requests are not sampled here so a master dropping REQ on ACK is served once.
                    rr_ptr <= (grant == GW'(NUM_MASTERS - 1)) ? '0 : grant + 1'b1;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode from registered state so an asynchronous reset clears them at once.
    assign bus.MEM_READ     = (state == ST_ACCESS) && !we_q;
    assign bus.MEM_WRITE    = (state == ST_ACCESS) && we_q;
    assign bus.MEM_ADDR     = (state == ST_ACCESS) ? addr_q : '0;
    assign bus.MEM_DATA_OUT = ((state == ST_ACCESS) && we_q) ? wdata_q : '0;
    assign bus.M_ACK        = (state == ST_DONE) ? (NUM_MASTERS'(1) << grant) : '0;
    assign bus.M_RDATA      = rdata_q;
    assign bus.BUSY         = (state == ST_ACCESS) || (state == ST_DONE);
    assign bus.GRANT_ID     = grant;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: two-master main instance, a four-master
// rotation instance and two three-master instances sweeping ACCESS_CYCLES.
module tb_mem_bus_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.NUM_MASTERS(2), .DATA_WIDTH(32), .ADDR_WIDTH(26)) i2 ();
    mem_bus_arbiter #(.NUM_MASTERS(2), .DATA_WIDTH(32), .ADDR_WIDTH(26), .ACCESS_CYCLES(2))
        u2 (.CLK(clk), .RST(rst_n), .bus(i2));

    mem_bus_arbiter_if #(.NUM_MASTERS(4), .DATA_WIDTH(32), .ADDR_WIDTH(26)) i4 ();
    mem_bus_arbiter #(.NUM_MASTERS(4), .DATA_WIDTH(32), .ADDR_WIDTH(26), .ACCESS_CYCLES(2))
        u4 (.CLK(clk), .RST(rst_n), .bus(i4));

    mem_bus_arbiter_if #(.NUM_MASTERS(3), .DATA_WIDTH(16), .ADDR_WIDTH(12)) ia1 ();
    mem_bus_arbiter #(.NUM_MASTERS(3), .DATA_WIDTH(16), .ADDR_WIDTH(12), .ACCESS_CYCLES(1))
        ua1 (.CLK(clk), .RST(rst_n), .bus(ia1));

    mem_bus_arbiter_if #(.NUM_MASTERS(3), .DATA_WIDTH(16), .ADDR_WIDTH(12)) ia5 ();
    mem_bus_arbiter #(.NUM_MASTERS(3), .DATA_WIDTH(16), .ADDR_WIDTH(12), .ACCESS_CYCLES(5))
        ua5 (.CLK(clk), .RST(rst_n), .bus(ia5));

    // Memory behind the two-master instance: combinational read, clocked write.
    logic [31:0] mem2 [0:1023];
    assign i2.MEM_DATA_IN = mem2[i2.MEM_ADDR[9:0]];
    always @(posedge clk) if (i2.MEM_WRITE) mem2[i2.MEM_ADDR[9:0]] <= i2.MEM_DATA_OUT;

    // Other instances read back a fixed function of the address.
    assign i4.MEM_DATA_IN  = 32'(i4.MEM_ADDR);
    assign ia1.MEM_DATA_IN = {4'h0, ia1.MEM_ADDR} ^ 16'hA5A5;
    assign ia5.MEM_DATA_IN = {4'h0, ia5.MEM_ADDR} ^ 16'hA5A5;

    logic [2:0]  sw_req;
    logic [2:0]  sw_we;
    logic [35:0] sw_addr;
    logic [47:0] sw_wdata;
    assign ia1.M_REQ = sw_req;   assign ia5.M_REQ = sw_req;
    assign ia1.M_WE = sw_we;     assign ia5.M_WE = sw_we;
    assign ia1.M_ADDR = sw_addr; assign ia5.M_ADDR = sw_addr;
    assign ia1.M_WDATA = sw_wdata; assign ia5.M_WDATA = sw_wdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One access on the two-master instance; master inputs are scrambled and REQ
    // dropped one cycle after the grant, which must not disturb the latched request.
    task automatic run_op(input logic [1:0] reqm, input logic we, input logic [25:0] addr,
                          input logic [31:0] wd, output logic [1:0] ack, output int lat,
                          output int rd_cnt, output int wr_cnt, output int busy_cnt,
                          output int both, output logic [31:0] wseen,
                          output logic [31:0] rdata, output logic gid);
        ack = '0; lat = 0; rd_cnt = 0; wr_cnt = 0; busy_cnt = 0; both = 0;
        wseen = '0; rdata = '0; gid = 1'b0;
        i2.M_REQ = reqm; i2.M_WE = {we, we}; i2.M_ADDR = {addr, addr}; i2.M_WDATA = {wd, wd};
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge clk);
            if (i2.MEM_READ) rd_cnt++;
            if (i2.MEM_WRITE) begin wr_cnt++; wseen = i2.MEM_DATA_OUT; end
            if (i2.BUSY) busy_cnt++;
            if (i2.MEM_READ && i2.MEM_WRITE) both++;
            if (i == 1) begin
                i2.M_REQ = '0; i2.M_WE = ~i2.M_WE; i2.M_ADDR = '1; i2.M_WDATA = '0;
            end
            if (i2.M_ACK != '0) begin
                ack = i2.M_ACK; lat = i; rdata = i2.M_RDATA; gid = i2.GRANT_ID;
            end
        end
        i2.M_REQ = '0;
        @(negedge clk);
    endtask

    logic [1:0]  ack;
    int          lat, rdc, wrc, bsy, bth;
    logic [31:0] ws, rd;
    logic        gid;
    logic [3:0]  ack4;
    int          acks, last_cyc;
    logic        ack_seen;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem2[i] = '0;
        mem2[10'h100] = 32'hDEAD_BEEF;
        i2.M_REQ = '0; i2.M_WE = '0; i2.M_ADDR = '0; i2.M_WDATA = '0;
        i4.M_REQ = '0; i4.M_WE = '0; i4.M_WDATA = '0;
        i4.M_ADDR = {26'h333, 26'h222, 26'h111, 26'h000};
        sw_req = '0; sw_we = '0; sw_wdata = '0;
        sw_addr = {12'h3C5, 12'h0AA, 12'h055};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ack", i2.M_ACK, 0);
        check("rst_rdata", i2.M_RDATA, 0);
        check("rst_mem_addr", i2.MEM_ADDR, 0);
        check("rst_mem_dout", i2.MEM_DATA_OUT, 0);
        check("rst_mem_read", i2.MEM_READ, 0);
        check("rst_mem_write", i2.MEM_WRITE, 0);
        check("rst_busy", i2.BUSY, 0);
        check("rst_grant", i2.GRANT_ID, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single read by M0
        run_op(2'b01, 1'b0, 26'h100, 32'h0, ack, lat, rdc, wrc, bsy, bth, ws, rd, gid);
        check("rd_ack", ack, 2'b01);
        check("rd_latency", lat, 3);
        check("rd_strobe_width", rdc, 2);
        check("rd_no_write", wrc, 0);
        check("rd_busy_cycles", bsy, 3);
        check("rd_data", rd, 32'hDEAD_BEEF);
        check("rd_grant", gid, 0);

        // M1 write, then M0 reads it back
        run_op(2'b10, 1'b1, 26'h2A0, 32'h0000_1234, ack, lat, rdc, wrc, bsy, bth, ws, rd, gid);
        check("wr_ack", ack, 2'b10);
        check("wr_latency", lat, 3);
        check("wr_strobe_width", wrc, 2);
        check("wr_no_read", rdc, 0);
        check("wr_data_out", ws, 32'h0000_1234);
        check("wr_keeps_rdata", rd, 32'hDEAD_BEEF);
        check("wr_grant", gid, 1);
        check("wr_no_overlap", bth, 0);
        run_op(2'b01, 1'b0, 26'h2A0, 32'h0, ack, lat, rdc, wrc, bsy, bth, ws, rd, gid);
        check("rdback_ack", ack, 2'b01);
        check("rdback_data", rd, 32'h0000_1234);
        check("rdback_strobe_width", rdc, 2);
        check("rdback_no_overlap", bth, 0);

        // Reset in the second ACCESS cycle of a read (pointer is 1 here)
        i2.M_REQ = 2'b01; i2.M_WE = '0; i2.M_ADDR = {26'h100, 26'h100};
        @(negedge clk);
        @(negedge clk);
        check("midrst_pre_read", i2.MEM_READ, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_read_low", i2.MEM_READ, 0);
        check("midrst_busy_low", i2.BUSY, 0);
        i2.M_REQ = '0;
        ack_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            ack_seen = ack_seen | (|i2.M_ACK);
        end
        check("midrst_no_ack", ack_seen, 0);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(2'b11, 1'b0, 26'h100, 32'h0, ack, lat, rdc, wrc, bsy, bth, ws, rd, gid);
        check("postrst_ptr0_ack", ack, 2'b01);
        check("postrst_latency", lat, 3);
        check("postrst_data", rd, 32'hDEAD_BEEF);

        // Contention from reset: both masters requesting continuously
        rst_n = 1'b0;
        i2.M_REQ = 2'b11; i2.M_WE = '0; i2.M_ADDR = {26'h100, 26'h100};
        @(negedge clk);
        rst_n = 1'b1;
        acks = 0; last_cyc = 0;
        for (int c = 1; c <= 60 && acks < 8; c++) begin
            @(negedge clk);
            if (i2.M_ACK != '0) begin
                check($sformatf("rr_ack%0d", acks), i2.M_ACK, (acks % 2 == 0) ? 2'b01 : 2'b10);
                check($sformatf("rr_grant%0d", acks), i2.GRANT_ID, acks % 2);
                if (acks == 0) check("rr_first_latency", c, 3);
                else check($sformatf("rr_spacing%0d", acks), c - last_cyc, 4);
                last_cyc = c;
                acks++;
            end
        end
        check("rr_ack_count", acks, 8);
        i2.M_REQ = '0;
        repeat (3) @(negedge clk);

        // Four masters: serve M1 so the pointer sits at 2, then M1 and M3 contend
        i4.M_REQ = 4'b0010;
        ack4 = '0;
        for (int c = 1; c <= 20 && ack4 == '0; c++) begin
            @(negedge clk);
            ack4 = i4.M_ACK;
            if (ack4 != '0) check("n4_m1_data", i4.M_RDATA, 32'h111);
        end
        check("n4_first_ack", ack4, 4'b0010);
        i4.M_REQ = '0;
        @(negedge clk);
        i4.M_REQ = 4'b1010;
        acks = 0;
        for (int c = 1; c <= 30 && acks < 2; c++) begin
            @(negedge clk);
            if (i4.M_ACK != '0) begin
                check($sformatf("n4_wrap_ack%0d", acks), i4.M_ACK, (acks == 0) ? 4'b1000 : 4'b0010);
                check($sformatf("n4_wrap_grant%0d", acks), i4.GRANT_ID, (acks == 0) ? 3 : 1);
                check($sformatf("n4_wrap_data%0d", acks), i4.M_RDATA, (acks == 0) ? 32'h333 : 32'h111);
                acks++;
            end
        end
        check("n4_wrap_count", acks, 2);
        i4.M_REQ = '0;
        @(negedge clk);

        // ACCESS_CYCLES sweep: 1 and 5, M2 reads 0x3C5 -> 0x03C5 ^ 0xA5A5 = 0xA660
        begin
            int rd1, rd5, lat1, lat5;
            logic [15:0] d1, d5;
            logic [2:0] a1, a5;
            rd1 = 0; rd5 = 0; lat1 = 0; lat5 = 0; d1 = '0; d5 = '0; a1 = '0; a5 = '0;
            sw_req = 3'b100;
            for (int c = 1; c <= 12; c++) begin
                @(negedge clk);
                if (c == 1) sw_req = '0;
                if (ia1.MEM_READ) rd1++;
                if (ia5.MEM_READ) rd5++;
                if (ia1.M_ACK != '0 && lat1 == 0) begin lat1 = c; d1 = ia1.M_RDATA; a1 = ia1.M_ACK; end
                if (ia5.M_ACK != '0 && lat5 == 0) begin lat5 = c; d5 = ia5.M_RDATA; a5 = ia5.M_ACK; end
            end
            check("ac1_strobe_width", rd1, 1);
            check("ac1_latency", lat1, 2);
            check("ac1_ack", a1, 3'b100);
            check("ac1_data", d1, 16'hA660);
            check("ac5_strobe_width", rd5, 5);
            check("ac5_latency", lat5, 6);
            check("ac5_ack", a5, 3'b100);
            check("ac5_data", d5, 16'hA660);
            check("ac5_grant", ia5.GRANT_ID, 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
